// File: rtl/sample_gen_pkg.sv
// Shared definitions for the sine sample source.
//   - default widths for the phase accumulator, quarter-wave ROM address and sample
//   - FSM state encoding (2 bits)
//   - quadrant constants for the phase decode
//   - apply_sign: turns a ROM magnitude into a signed full-wave sample
package sample_gen_pkg;

    localparam int PHASE_W  = 22;
    localparam int ADDR_W   = 10;
    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_READ = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Quadrant bit 0 mirrors the ROM address, bit 1 negates the sample.
    localparam logic [1:0] QUAD_0 = 2'd0;
    localparam logic [1:0] QUAD_1 = 2'd1;
    localparam logic [1:0] QUAD_2 = 2'd2;
    localparam logic [1:0] QUAD_3 = 2'd3;

    // The ROM magnitude never exceeds 2^(SAMPLE_W-1)-1, so negating it cannot overflow.
    function automatic logic [SAMPLE_W-1:0] apply_sign(input logic [SAMPLE_W-2:0] magnitude,
                                                       input logic             negate);
        logic [SAMPLE_W-1:0] extended;
        extended = {1'b0, magnitude};
        if (negate) begin
            return (~extended) + {{(SAMPLE_W-1){1'b0}}, 1'b1};
        end else begin
            return extended;
        end
    endfunction

endpackage

// File: rtl/sine_rom.sv
// Quarter-wave sine ROM with a one-cycle registered read.
// Entry i = round(full_scale * sin(pi/2 * (i + 0.5) / DEPTH)), full_scale = 2^DATA_W - 1.
// Ports:
//   clk   in   clock
//   reset in   asynchronous active-low reset (clears the read register)
//   addr  in   ADDR_W-bit table index
//   data  out  DATA_W-bit unsigned magnitude, valid the cycle after addr
module sine_rom
    import sample_gen_pkg::*;
#(
    parameter int ROM_ADDR_W = ADDR_W,
    parameter int DATA_W     = SAMPLE_W - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ROM_ADDR_W-1:0] addr,
    output logic [DATA_W-1:0]     data
);

    localparam int DEPTH = 1 << ROM_ADDR_W;

    // Evaluated only at elaboration to build the constant table.
    function automatic logic [DATA_W-1:0] sine_entry(input int idx);
        real half_pi;
        real full_scale;
        real angle;
        real value;
        half_pi    = 1.57079632679489661923;
        full_scale = real'((1 << DATA_W) - 1);
        angle      = half_pi * (real'(idx) + 0.5) / real'(DEPTH);
        value      = full_scale * $sin(angle);
        return DATA_W'($rtoi(value + 0.5));
    endfunction

    logic [DATA_W-1:0] table_data [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_table
        localparam logic [DATA_W-1:0] ENTRY = sine_entry(i);
        assign table_data[i] = ENTRY;
    end

    // Registered read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data <= {DATA_W{1'b0}};
        end else begin
            data <= table_data[addr];
        end
    end

endmodule

// File: rtl/sine_sample_source.sv
// Sine sample producer: each request advances a phase accumulator, looks up a
// quarter-wave ROM, rebuilds the full-wave sample by symmetry and presents it with
// a one-cycle strobe.
// Ports:
//   clk                  in   system clock
//   reset                in   asynchronous active-low reset
//   step_size            in   unsigned phase increment per sample (sampled in OUT)
//   play                 in   1 = sine, 0 = silence and phase clear (sampled in ADDR)
//   generate_next_sample in   one-cycle request pulse
//   new_sample_out       out  signed sample, held between strobes
//   latch_new_sample_out out  one-cycle strobe qualifying new_sample_out
//   overrun              out  sticky: request arrived while busy
module sine_sample_source
    import sample_gen_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [PHASE_W-1:0]  step_size,
    input  logic                play,
    input  logic                generate_next_sample,
    output logic [SAMPLE_W-1:0] new_sample_out,
    output logic                latch_new_sample_out,
    output logic                overrun
);

    state_t              state;
    state_t              next_state;
    logic [PHASE_W-1:0]  phase;
    logic [1:0]          quadrant;
    logic                play_flag;
    logic [ADDR_W-1:0]   rom_addr;
    logic [SAMPLE_W-2:0] rom_data;
    logic [1:0]          phase_quad;
    logic [ADDR_W-1:0]   phase_index;

    assign phase_quad  = phase[PHASE_W-1 -: 2];
    assign phase_index = phase[PHASE_W-3 -: ADDR_W];

    sine_rom #(
        .ROM_ADDR_W (ADDR_W),
        .DATA_W     (SAMPLE_W - 1)
    ) u_rom (
        .clk   (clk),
        .reset (reset),
        .addr  (rom_addr),
        .data  (rom_data)
    );

    // ROM address: odd quadrants walk the quarter wave backwards. The ROM samples
    // this every cycle; the value captured while in ADDR is the one used in OUT,
    // since phase only changes on leaving OUT.
    always_comb begin
        rom_addr = phase_index;
        case (phase_quad)
            QUAD_0:  rom_addr = phase_index;
            QUAD_1:  rom_addr = ~phase_index;
            QUAD_2:  rom_addr = phase_index;
            QUAD_3:  rom_addr = ~phase_index;
            default: rom_addr = phase_index;
        endcase
    end

    // Next-state logic for the request sequencer.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (generate_next_sample) begin
                    next_state = ST_ADDR;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_ADDR: next_state = ST_READ;
            ST_READ: next_state = ST_OUT;
            ST_OUT:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath: quadrant/play capture, sample output, strobe, phase and overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase                <= {PHASE_W{1'b0}};
            quadrant             <= QUAD_0;
            play_flag            <= 1'b0;
            new_sample_out       <= {SAMPLE_W{1'b0}};
            latch_new_sample_out <= 1'b0;
            overrun              <= 1'b0;
        end else begin
            latch_new_sample_out <= 1'b0;
            // Any request outside IDLE (including the cycle OUT hands back) is dropped.
            if (generate_next_sample && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            if (state == ST_ADDR) begin
                quadrant  <= phase_quad;
                play_flag <= play;
            end
            if (state == ST_OUT) begin
                latch_new_sample_out <= 1'b1;
                if (play_flag) begin
                    new_sample_out <= apply_sign(rom_data, quadrant[1]);
                end else begin
                    new_sample_out <= {SAMPLE_W{1'b0}};
                end
                if (play_flag) begin
                    phase <= phase + step_size;
                end else begin
                    phase <= {PHASE_W{1'b0}};
                end
            end
        end
    end

endmodule
